mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the processor's instruction-fetch port
//  (read-only) and its data port (read/write). Replaces the dual-read/single-write memory

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM states, port owners and the
// data-streak counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  // Wide enough for MAX_DSTREAK up to 15.
  localparam int unsigned StreakW = 4;

  function automatic logic [StreakW-1:0] streak_inc(input logic [StreakW-1:0] s);
    return (s == '1) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters. Data wins ties until it has been
// granted MAX_DSTREAK times in a row while fetch was waiting.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_d
);

  localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_DSTREAK);

  logic [StreakW-1:0] streak_q, streak_d;
  logic               fetch_turn;

  assign fetch_turn = if_req && (streak_q >= MaxStreak);

  always_comb begin
    grant_if = grant_en & if_req & (~d_req | fetch_turn);
    grant_d  = grant_en & d_req & ~fetch_turn;
  end

  // Streak only counts data grants that made a waiting fetch wait longer.
  always_comb begin
    streak_d = streak_q;
    if (!if_req) begin
      streak_d = '0;
    end else if (grant_if) begin
      streak_d = '0;
    end else if (grant_d) begin
      streak_d = streak_inc(streak_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch port and the
// data port. One access per two cycles: ISSUE drives the strobe, RESP returns the ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned MAX_DSTREAK = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          grant_en, grant_if, grant_d;

  // Arbitrate only where a new access can start: from idle or at the end of an ack.
  assign grant_en = (state_q == StIdle) || (state_q == StResp);

  mem_arb_pick #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .d_req   (d_req),
    .grant_en(grant_en),
    .grant_if(grant_if),
    .grant_d (grant_d)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (grant_d) begin
          state_d     = StIssue;
          owner_d     = OwnD;
          we_d        = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_if) begin
          state_d     = StIssue;
          owner_d     = OwnIf;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end else begin
          state_d = StIdle;
          owner_d = OwnNone;
          we_d    = 1'b0;
        end
      end
      StIssue: begin
        state_d = StResp;
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Read data arrives from memory during RESP and is passed straight to the owner.
  always_comb begin
    if_ack   = 1'b0;
    d_ack    = 1'b0;
    if_rdata = '0;
    d_rdata  = '0;
    if (state_q == StResp) begin
      case (owner_q)
        OwnIf: begin
          if_ack   = 1'b1;
          if_rdata = mem_rdata;
        end
        OwnD: begin
          d_ack   = 1'b1;
          d_rdata = we_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected acks, a negedge monitor
// pops and compares them; directed checks cover latency, reset and write commit.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_DSTREAK(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Single-port synchronous memory: read data valid the cycle after the strobe.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic          is_d;
    logic [DW-1:0] rdata;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ack_cyc = -1;
  int   we_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t          e;
    logic [DW-1:0] rd;
    if (mem_we) begin
      we_cnt++;
      if (!mem_en) begin
        checks++;
        errors++;
        $display("FAIL we_without_en: mem_we=1 mem_en=%0b at cycle %0d", mem_en, cyc);
      end
    end
    if (if_ack || d_ack) begin
      checks++;
      if (if_ack && d_ack) begin
        errors++;
        $display("FAIL both_acks: if_ack=1 d_ack=1 at cycle %0d, required at most one", cyc);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b at cycle %0d, none expected",
                 if_ack, d_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (d_ack !== e.is_d) begin
          errors++;
          $display("FAIL ack_port: got d_ack=%0b if_ack=%0b, required d_ack=%0b (cycle %0d)",
                   d_ack, if_ack, e.is_d, cyc);
        end
        rd = e.is_d ? d_rdata : if_rdata;
        checks++;
        if (rd !== e.rdata) begin
          errors++;
          $display("FAIL ack_rdata: got 0x%08h required 0x%08h (cycle %0d)", rd, e.rdata, cyc);
        end
        if (e.gap != 0) begin
          checks++;
          if (cyc - last_ack_cyc != e.gap) begin
            errors++;
            $display("FAIL ack_gap: got %0d cycles required %0d (cycle %0d)",
                     cyc - last_ack_cyc, e.gap, cyc);
          end
        end
      end
      last_ack_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [DW-1:0] rdata, input int gap);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // Returns on the negedge of the n-th ack, so the caller may drop or change requests
  // before the edge that ends that ack cycle.
  task automatic wait_acks(input int n);
    int got = 0;
    int budget = 4 * n + 10;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (if_ack || d_ack) got++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got %0d acks required %0d", got, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0200] = 32'hA5A5A5A5;

    // Reset state, before any clock edge.
    #2;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: fetch only, latency and 2-cycle repeat.
    push(1'b0, 32'hDEADBEEF, 0);
    push(1'b0, 32'hDEADBEEF, 2);
    push(1'b0, 32'hDEADBEEF, 2);
    if_addr = 16'h0010;
    if_req  = 1'b1;
    @(negedge clk);
    check("t1_issue_mem_en", {31'd0, mem_en}, 32'd1);
    check("t1_issue_mem_we", {31'd0, mem_we}, 32'd0);
    check("t1_issue_addr", {16'd0, mem_addr}, 32'h10);
    check("t1_issue_ack", {31'd0, if_ack}, 32'd0);
    @(negedge clk);
    check("t1_resp_if_ack", {31'd0, if_ack}, 32'd1);
    check("t1_resp_mem_en", {31'd0, mem_en}, 32'd0);
    wait_acks(2);
    if_req = 1'b0;

    // 2: write then read of the same word, back to back.
    w0 = we_cnt;
    push(1'b1, 32'h0, 0);
    push(1'b1, 32'h12345678, 2);
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0100;
    d_wdata = 32'h12345678;
    wait_acks(1);
    d_we = 1'b0;
    wait_acks(1);
    d_req = 1'b0;
    @(negedge clk);
    check("t2_we_cycles", 32'(we_cnt - w0), 32'd1);
    check("t2_mem_commit", mem[16'h0100], 32'h12345678);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // 3: simultaneous requests from idle: data first, then fetch.
    push(1'b1, 32'h12345678, 0);
    push(1'b0, 32'hDEADBEEF, 2);
    d_req   = 1'b1;
    if_req  = 1'b1;
    wait_acks(1);
    d_req = 1'b0;
    wait_acks(1);

    // 4: both held: D,D,D,IF,D,D,D,IF.
    push(1'b1, 32'h12345678, 0);
    push(1'b1, 32'h12345678, 2);
    push(1'b1, 32'h12345678, 2);
    push(1'b0, 32'hDEADBEEF, 2);
    push(1'b1, 32'h12345678, 2);
    push(1'b1, 32'h12345678, 2);
    push(1'b1, 32'h12345678, 2);
    push(1'b0, 32'hDEADBEEF, 2);
    d_req = 1'b1;
    wait_acks(8);
    d_req  = 1'b0;
    if_req = 1'b0;
    @(negedge clk);

    // 5: reset in the middle of a write's ISSUE cycle.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0200;
    d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("t5_issue_mem_we", {31'd0, mem_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("t5_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_addr", {16'd0, mem_addr}, 32'd0);
    check("t5_rst_wdata", mem_wdata, 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t5_mem_unchanged", mem[16'h0200], 32'hA5A5A5A5);
    repeat (4) @(negedge clk);
    check("t5_still_idle", {31'd0, busy}, 32'd0);

    // 6: d_req dropped during ISSUE still completes with a single ack.
    push(1'b1, 32'h12345678, 0);
    d_req  = 1'b1;
    d_addr = 16'h0100;
    @(negedge clk);
    check("t6_issue_mem_en", {31'd0, mem_en}, 32'd1);
    d_req = 1'b0;
    wait_acks(1);
    @(negedge clk);
    check("t6_back_idle", {31'd0, busy}, 32'd0);
    check("t6_no_second_ack", {31'd0, d_ack}, 32'd0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
